// File: rtl/pea_pkg.sv
// Shared constants for the command fetch path and the execution FSM:
// opcodes, field widths, fetch state encoding and the address-width helper.
package pea_pkg;

   localparam int OPC_W = 3;

   localparam logic [OPC_W-1:0] OPC_STP = 3'b000;
   localparam logic [OPC_W-1:0] OPC_EVP = 3'b001;
   localparam logic [OPC_W-1:0] OPC_EVB = 3'b010;
   localparam logic [OPC_W-1:0] OPC_RST = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPT,
      S_EXT_WAIT,
      S_EXT_FETCH,
      S_EXT_CAPT,
      S_ISSUE,
      S_ILL
   } state_t;

   function automatic int log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/cmd_opc_decode.sv
// Opcode classifier shared by command fetch and the execution FSM.
// Codes with the top bit set are illegal.
module cmd_opc_decode
   import pea_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             is_two_word,
   output logic             is_legal,
   output logic             is_rst
);

   always_comb begin
      is_two_word = 1'b0;
      is_legal    = 1'b0;
      is_rst      = 1'b0;
      case (opcode)
         OPC_STP: begin
            is_legal    = 1'b1;
            is_two_word = 1'b1;
         end
         OPC_EVP: is_legal = 1'b1;
         OPC_EVB: begin
            is_legal    = 1'b1;
            is_two_word = 1'b1;
         end
         OPC_RST: begin
            is_legal = 1'b1;
            is_rst   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cmd_fetch.sv
// Command fetch/decode stage: reads tokens from the Command RAM and issues
// 1/2-word instructions. CMD_FETCH_ILLEGAL_TRAP_EN makes illegal opcodes trap.
module cmd_fetch
   import pea_pkg::*;
#(
   parameter  int word_size   = 16,
   parameter  int buffer_size = 1024,
   localparam int AW          = log2(buffer_size),
   localparam int ARG_W       = word_size - OPC_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        cmd_wr_addr,
   output logic                 ram_rd_en,
   output logic [AW-1:0]        ram_rd_addr,
   input  logic [word_size-1:0] ram_rd_data,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [OPC_W-1:0]     instr_opcode,
   output logic [ARG_W-1:0]     instr_arg,
   output logic [word_size-1:0] instr_ext,
   output logic                 flush,
   output logic                 err
);

   state_t state;
   state_t state_nxt;

   logic [AW-1:0]    rd_ptr;
   logic             non_empty;
   logic             accept;
   logic [OPC_W-1:0] dec_opc;
   logic             dec_two;
   logic             dec_legal;
   logic             dec_rst;

   assign non_empty = (rd_ptr != cmd_wr_addr);
   assign accept    = (state == S_ISSUE) && instr_ready;

   // Classify the fresh RAM word in CAPT, the held opcode otherwise.
   assign dec_opc = (state == S_CAPT)
                  ? ram_rd_data[word_size-1 -: OPC_W]
                  : instr_opcode;

   cmd_opc_decode u_dec (
      .opcode      (dec_opc),
      .is_two_word (dec_two),
      .is_legal    (dec_legal),
      .is_rst      (dec_rst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (non_empty) state_nxt = S_FETCH;
         S_FETCH:     state_nxt = S_CAPT;
         S_CAPT: begin
            if (!dec_legal)   state_nxt = S_ILL;
            else if (dec_two) state_nxt = S_EXT_WAIT;
            else              state_nxt = S_ISSUE;
         end
         S_EXT_WAIT:  if (non_empty) state_nxt = S_EXT_FETCH;
         S_EXT_FETCH: state_nxt = S_EXT_CAPT;
         S_EXT_CAPT:  state_nxt = S_ISSUE;
         S_ISSUE:     if (instr_ready) state_nxt = S_IDLE;
`ifdef CMD_FETCH_ILLEGAL_TRAP_EN
         S_ILL:       state_nxt = S_ILL;
`else
         S_ILL:       state_nxt = S_IDLE;
`endif
      endcase
   end

   always_comb begin
      ram_rd_en   = (state == S_FETCH) || (state == S_EXT_FETCH);
      ram_rd_addr = rd_ptr;
      instr_valid = (state == S_ISSUE);
   end

   // Fields only move in the capture states, so they hold under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr       <= '0;
         instr_opcode <= '0;
         instr_arg    <= '0;
         instr_ext    <= '0;
         flush        <= 1'b0;
      end else begin
         flush <= 1'b0;
         if (state == S_CAPT) begin
            instr_opcode <= ram_rd_data[word_size-1 -: OPC_W];
            instr_arg    <= ram_rd_data[ARG_W-1:0];
            instr_ext    <= '0;
            rd_ptr       <= rd_ptr + 1'b1;
         end
         if (state == S_EXT_CAPT) begin
            instr_ext <= ram_rd_data;
            rd_ptr    <= rd_ptr + 1'b1;
         end
         if (accept && dec_rst) begin
            flush  <= 1'b1;
            rd_ptr <= '0;
         end
      end
   end

`ifdef CMD_FETCH_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                err <= 1'b0;
      else if (state == S_ILL) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_fetch.sv
// Self-checking bench for cmd_fetch: directed scenarios plus a randomized
// instruction stream checked against a queue-based reference model.
module tb_cmd_fetch;

   localparam int WS = 16;
   localparam int BS = 1024;
   localparam int AW = 10;

   typedef struct {
      logic [2:0]  opc;
      logic [12:0] arg;
      logic [15:0] ext;
   } instr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cmd_wr_addr;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [WS-1:0] ram_rd_data = '0;
   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    instr_opcode;
   logic [12:0]   instr_arg;
   logic [15:0]   instr_ext;
   logic          flush;
   logic          err;

   logic [15:0] mem [BS];
   instr_t      exp_q[$];
   int          errors = 0;
   int          checks = 0;

   cmd_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_wr_addr  (cmd_wr_addr),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_opcode (instr_opcode),
      .instr_arg    (instr_arg),
      .instr_ext    (instr_ext),
      .flush        (flush),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

   task automatic wait_valid(input int max, output bit ok);
      int n;
      n = 0;
      while (!instr_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      ok = instr_valid;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cmd_wr_addr = '0;
      instr_ready = 1'b0;
      for (int i = 0; i < BS; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ram_rd_en, ram_rd_addr, instr_valid, instr_opcode, instr_arg,
           instr_ext, flush, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got en=%b addr=%0d v=%b op=%0d arg=%h ext=%h fl=%b err=%b exp all 0",
                  ram_rd_en, ram_rd_addr, instr_valid, instr_opcode, instr_arg,
                  instr_ext, flush, err);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ram_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got en=%b v=%b exp 0 0", ram_rd_en, instr_valid);
      end
   endtask

   task automatic test_one_word();
      mem[0] = 16'h2005;
      cmd_wr_addr = 10'd1;
      @(negedge clk);
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 10'd0) begin
         errors++;
         $display("FAIL ow_fetch got en=%b addr=%0d exp 1 0", ram_rd_en, ram_rd_addr);
      end
      @(negedge clk);
      checks++;
      if (ram_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ow_capt got en=%b v=%b exp 0 0", ram_rd_en, instr_valid);
      end
      @(negedge clk);
      checks++;
      if ({instr_valid, instr_opcode, instr_arg, instr_ext, ram_rd_addr} !==
          {1'b1, 3'd1, 13'd5, 16'h0, 10'd1}) begin
         errors++;
         $display("FAIL ow_issue got v=%b op=%0d arg=%0d ext=%h ptr=%0d exp 1 1 5 0000 1",
                  instr_valid, instr_opcode, instr_arg, instr_ext, ram_rd_addr);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ow_accept got v=%b exp 0", instr_valid);
      end
   endtask

   task automatic test_ext_wait();
      bit ok;
      bit bad;
      mem[1] = 16'h0123;
      cmd_wr_addr = 10'd2;
      repeat (3) @(negedge clk);
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ram_rd_en !== 1'b0 || instr_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL ext_wait_hold got activity=1 exp 0");
      end
      mem[2] = 16'hBEEF;
      cmd_wr_addr = 10'd3;
      wait_valid(20, ok);
      checks++;
      if (!ok || {instr_opcode, instr_arg, instr_ext} !== {3'd0, 13'h0123, 16'hBEEF}) begin
         errors++;
         $display("FAIL ext_issue got v=%b op=%0d arg=%h ext=%h exp 1 0 0123 beef",
                  instr_valid, instr_opcode, instr_arg, instr_ext);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      bit bad;
      mem[3] = 16'h40AA;
      mem[4] = 16'h1234;
      cmd_wr_addr = 10'd5;
      wait_valid(20, ok);
      bad = !ok;
      repeat (10) begin
         @(negedge clk);
         if ({instr_valid, instr_opcode, instr_arg, instr_ext, ram_rd_en} !==
             {1'b1, 3'd2, 13'h00AA, 16'h1234, 1'b0}) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_stable got v=%b op=%0d arg=%h ext=%h en=%b exp 1 2 00aa 1234 0",
                  instr_valid, instr_opcode, instr_arg, instr_ext, ram_rd_en);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || ram_rd_addr !== 10'd5) begin
         errors++;
         $display("FAIL bp_accept got v=%b ptr=%0d exp 0 5", instr_valid, ram_rd_addr);
      end
   endtask

   task automatic test_random_stream();
      int     a;
      int     kind;
      int     cyc_n;
      int     tmp;
      int     bad;
      instr_t e;
      exp_q.delete();
      a = 5;
      while (a < BS - 1) begin
         kind = (BS - 1 - a >= 2) ? $urandom_range(0, 2) : 1;
         e.opc = kind[2:0];
         e.arg = 13'($urandom);
         e.ext = (kind != 1) ? 16'($urandom) : 16'h0;
         mem[a] = {e.opc, e.arg};
         a++;
         if (kind != 1) begin
            mem[a] = e.ext;
            a++;
         end
         exp_q.push_back(e);
      end
      cyc_n = 0;
      bad = 0;
      while (exp_q.size() > 0 && cyc_n < 20000) begin
         @(negedge clk);
         cyc_n++;
         if (cmd_wr_addr != 10'(BS - 1) && $urandom_range(0, 3) == 0) begin
            tmp = int'(cmd_wr_addr) + $urandom_range(1, 4);
            if (tmp > BS - 1) tmp = BS - 1;
            cmd_wr_addr = tmp[AW-1:0];
         end
         instr_ready = 1'($urandom_range(0, 1));
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            checks++;
            if ({instr_opcode, instr_arg, instr_ext} !== {e.opc, e.arg, e.ext}) begin
               errors++;
               if (bad < 5)
                  $display("FAIL rand_instr got op=%0d arg=%h ext=%h exp op=%0d arg=%h ext=%h",
                           instr_opcode, instr_arg, instr_ext, e.opc, e.arg, e.ext);
               bad++;
            end
         end
      end
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_timeout got pending=%0d exp 0", exp_q.size());
      end
      @(negedge clk);
      checks++;
      if (ram_rd_addr !== 10'd1023 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_end_ptr got ptr=%0d v=%b exp 1023 0", ram_rd_addr, instr_valid);
      end
   endtask

   task automatic test_wrap();
      logic [12:0] a0;
      logic [12:0] a1;
      logic [12:0] got [2];
      int          n;
      int          cyc_n;
      a0 = 13'($urandom);
      a1 = 13'($urandom);
      mem[1023] = {3'd1, a0};
      mem[0]    = {3'd1, a1};
      cmd_wr_addr = 10'd1;
      instr_ready = 1'b1;
      n = 0;
      cyc_n = 0;
      while (n < 2 && cyc_n < 40) begin
         @(negedge clk);
         cyc_n++;
         if (instr_valid) begin
            got[n] = instr_arg;
            n++;
         end
      end
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (n != 2 || got[0] !== a0 || got[1] !== a1) begin
         errors++;
         $display("FAIL wrap_order got n=%0d a=%h,%h exp 2 a=%h,%h", n, got[0], got[1], a0, a1);
      end
      checks++;
      if (ram_rd_addr !== 10'd1) begin
         errors++;
         $display("FAIL wrap_ptr got %0d exp 1", ram_rd_addr);
      end
   endtask

   task automatic test_rst_flush();
      bit ok;
      int rd_seen;
      mem[1] = 16'h6000;
      for (int i = 2; i < 5; i++) mem[i] = {3'd1, 13'($urandom)};
      cmd_wr_addr = 10'd5;
      wait_valid(20, ok);
      checks++;
      if (!ok || instr_opcode !== 3'd3 || flush !== 1'b0) begin
         errors++;
         $display("FAIL flush_issue got v=%b op=%0d fl=%b exp 1 3 0", instr_valid, instr_opcode, flush);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (flush !== 1'b1 || ram_rd_addr !== 10'd0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_pulse got fl=%b ptr=%0d v=%b exp 1 0 0", flush, ram_rd_addr, instr_valid);
      end
      cmd_wr_addr = 10'd0;
      @(negedge clk);
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL flush_width got %b exp 0", flush);
      end
      rd_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (ram_rd_en) rd_seen++;
      end
      checks++;
      if (rd_seen != 0) begin
         errors++;
         $display("FAIL flush_discard got reads=%0d exp 0", rd_seen);
      end
   endtask

   task automatic test_rst_mid();
      bit bad;
      mem[0] = 16'h2077;
      cmd_wr_addr = 10'd1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({ram_rd_en, ram_rd_addr, instr_valid, instr_opcode, instr_arg,
           instr_ext, flush, err} !== '0) begin
         errors++;
         $display("FAIL mid_reset got en=%b addr=%0d v=%b op=%0d arg=%h ext=%h fl=%b err=%b exp all 0",
                  ram_rd_en, ram_rd_addr, instr_valid, instr_opcode, instr_arg,
                  instr_ext, flush, err);
      end
      cmd_wr_addr = 10'd0;
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (instr_valid || ram_rd_en) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL mid_discard got activity=1 exp 0");
      end
   endtask

   task automatic test_illegal();
      int rd_seen;
      int issued;
      logic [2:0]  op;
      logic [12:0] arg;
      mem[0] = 16'hE000;
      mem[1] = 16'h2007;
      cmd_wr_addr = 10'd2;
      instr_ready = 1'b1;
      rd_seen = 0;
      issued = 0;
      op = '0;
      arg = '0;
      repeat (25) begin
         @(negedge clk);
         if (ram_rd_en) rd_seen++;
         if (instr_valid) begin
            issued++;
            op = instr_opcode;
            arg = instr_arg;
         end
      end
      instr_ready = 1'b0;
`ifdef CMD_FETCH_ILLEGAL_TRAP_EN
      checks++;
      if (err !== 1'b1 || rd_seen != 1 || issued != 0) begin
         errors++;
         $display("FAIL ill_trap got err=%b reads=%0d issued=%0d exp 1 1 0", err, rd_seen, issued);
      end
      checks++;
      if (ram_rd_addr !== 10'd1) begin
         errors++;
         $display("FAIL ill_trap_ptr got %0d exp 1", ram_rd_addr);
      end
`else
      checks++;
      if (issued != 1 || op !== 3'd1 || arg !== 13'd7 || err !== 1'b0) begin
         errors++;
         $display("FAIL ill_skip got issued=%0d op=%0d arg=%0d err=%b exp 1 1 7 0",
                  issued, op, arg, err);
      end
      checks++;
      if (ram_rd_addr !== 10'd2 || rd_seen != 2) begin
         errors++;
         $display("FAIL ill_skip_ptr got ptr=%0d reads=%0d exp 2 2", ram_rd_addr, rd_seen);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_one_word();
      test_ext_wait();
      test_backpressure();
      test_random_stream();
      test_wrap();
      test_rst_flush();
      test_rst_mid();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
